adder_nbit_serial_display: RTL
==============================

// Module: adder_nbit_serial_display
// PURPOSE
//  Parametrised successor of the 8-bit adder/display block. Adds two WIDTH-bit operands
//  nibble-serially (one 4-bit slice per clock) under a start/busy/done handshake.
//  Registers the result and drives one 7-segment digit per result nibble.
//  Top-level board glue between switch/operand sources and the HEX displays.
// PARAMETERS
//  WIDTH           16  operand/sum width; must be a multiple of 4, >=8; NDIG = WIDTH/4 (localparam)
//  SEG_ACTIVE_LOW   1  1: segment on = 0 (DE-series boards); 0: segment on = 1
// PORTS
//  clk    in   1        sole clock; all logic on posedge
//  rst    in   1        synchronous, active-high reset
//  start  in   1        request; accepted only when busy=0
//  a      in   WIDTH    operand A, sampled at accept edge only
//  b      in   WIDTH    operand B, sampled at accept edge only
//  cin    in   1        carry in, sampled at accept edge only
//  busy   out  1        1 while an addition is in progress
//  done   out  1        one-cycle pulse: sum/cout/hex just updated
//  sum    out  WIDTH    registered result, (a+b+cin) mod 2^WIDTH
//  cout   out  1        registered carry out of bit WIDTH-1
//  hex    out  7*NDIG   digit i = hex[7i+6:7i] shows sum[4i+3:4i]; seg order {g,f,e,d,c,b,a}
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE, busy=0, done=0, sum=0, cout=0, hex=every digit "0"
//   (7'h40 active-low, 7'h3F active-high); operand regs and nibble index cleared.
//  FSM: IDLE --start--> ADD --(idx==NDIG-1)--> IDLE.
//  IDLE: start=1 at edge: capture a,b,cin into op regs, carry<=cin, idx<=0, busy<=1, -> ADD.
//  ADD: each edge: {carry,res[idx]} <= opa[idx]+opb[idx]+carry; idx<=idx+1.
//   On edge processing idx==NDIG-1: sum<=final result, cout<=final carry, hex<=decode(sum),
//   done<=1, busy<=0, -> IDLE.
//  Latency: start edge to done=1 = NDIG cycles (4 for WIDTH=16); throughput 1 op / NDIG cycles.
//  done is high exactly one cycle; otherwise 0.
//  start while busy=1: ignored, no effect on operation in flight.
//  start=1 in the done cycle (busy=0): accepted; back-to-back ops allowed, no bubble.
//  sum/cout/hex hold the previous result during ADD; partial sums never visible.
//  a/b/cin changes during ADD: no effect.
//  Wrap-around: sum modulo 2^WIDTH, overflow reported only via cout.
//  rst during ADD: operation aborted, no done pulse, all outputs to reset values next cycle.
//  Decoder: full hex 0-F (A,b,C,d,E,F); polarity per SEG_ACTIVE_LOW.
// CONFIGURATION
//  ADDER_NBIT_ACCUM_EN defined: extra input port acc (1 bit, after cin). When start accepted
//   with acc=1, operand A is the current sum register instead of a (running accumulator);
//   acc=0 behaves as plain add. acc sampled only at accept edge.
//  Not defined: no acc port; operand A is always a.
// TESTING (WIDTH=16, SEG_ACTIVE_LOW=1)
//  Reset: rst=1 for 2 cycles -> sum=0, cout=0, busy=0, done=0, hex={4{7'h40}}.
//  a=16'h1234, b=16'h4321, cin=0, start 1 cycle -> busy 4 cycles, done pulse, sum=16'h5555, cout=0, hex={4{7'h12}}.
//  a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1; a=16'hFFFF, b=0, cin=1 -> same.
//  start held high with changing a/b while busy -> first captured op only; re-start in done cycle -> second done 4 cycles later.
//  rst=1 in 2nd ADD cycle -> no done pulse, sum=0, busy=0 next cycle.
//  ADDER_NBIT_ACCUM_EN: a=16'h0010, b=16'h0005 -> 16'h0015; then acc=1, b=16'h0001 -> 16'h0016.

Source files
------------

// File: rtl/adder_nbit_serial_display.sv
// Nibble-serial WIDTH-bit adder with registered sum and per-nibble 7-segment digits.
// Optional ADDER_NBIT_ACCUM_EN adds an acc input: operand A becomes the current sum.
module adder_nbit_serial_display #(
  parameter int WIDTH          = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  input  logic                       cin,
`ifdef ADDER_NBIT_ACCUM_EN
  input  logic                       acc,
`endif
  output logic                       busy,
  output logic                       done,
  output logic [WIDTH-1:0]           sum,
  output logic                       cout,
  output logic [7*(WIDTH/4)-1:0]     hex
);

  localparam int NDIG = WIDTH / 4;
  localparam int IW   = $clog2(NDIG);

  typedef enum logic {IDLE, ADD} state_t;

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_n;
  logic [WIDTH-1:0] opa_src;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [4:0]       nib;
  logic             last;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return SEG_ACTIVE_LOW ? ~s : s;
  endfunction

`ifdef ADDER_NBIT_ACCUM_EN
  assign opa_src = acc ? sum : a;
`else
  assign opa_src = a;
`endif

  // One nibble per cycle; res_n is the result with the current nibble merged in
  always_comb begin
    nib   = {1'b0, opa[{idx, 2'b00} +: 4]}
          + {1'b0, opb[{idx, 2'b00} +: 4]}
          + {4'b0, carry};
    res_n = res;
    res_n[{idx, 2'b00} +: 4] = nib[3:0];
    last  = (idx == IW'(NDIG - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      hex   <= {NDIG{seg7(4'h0)}};
      opa   <= '0;
      opb   <= '0;
      res   <= '0;
      carry <= 1'b0;
      idx   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            opa   <= opa_src;
            opb   <= b;
            carry <= cin;
            res   <= '0;
            idx   <= '0;
            busy  <= 1'b1;
            state <= ADD;
          end
        end
        ADD: begin
          carry <= nib[4];
          res   <= res_n;
          idx   <= idx + IW'(1);
          if (last) begin
            sum   <= res_n;
            cout  <= nib[4];
            for (int i = 0; i < NDIG; i++)
              hex[7*i +: 7] <= seg7(res_n[4*i +: 4]);
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
